// File: rtl/div3_check_scheduler_if.sv
// ---------------------------------------------------------------------------
// div3_check_scheduler_if
// Request/response bundle between number producers, the shared divisible-by-3
// scheduler and the single result consumer.
//
//   req_valid  [NREQ]     producer -> scheduler, bit i: requester i pending
//   req_number [16*NREQ]  producer -> scheduler, requester i at [16*i +: 16]
//   req_ready  [NREQ]     scheduler -> producer, one-hot grant
//   rsp_valid             scheduler -> consumer, response available
//   rsp_ready             consumer -> scheduler, response accepted
//   rsp_id     [3]        granted requester index
//   rsp_number [16]       original number as accepted
//   rsp_div3              1 when rsp_number mod 3 == 0
//
// Modports: master = producer/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface div3_check_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_number;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [15:0]          rsp_number;
    logic                 rsp_div3;

    modport master (
        output req_valid, req_number, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_number, rsp_div3
    );

    modport slave (
        input  req_valid, req_number, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_number, rsp_div3
    );
endinterface

// File: rtl/div3_check_scheduler.sv
// ---------------------------------------------------------------------------
// div3_check_scheduler
// Round-robin arbiter in front of one iterative divisible-by-3 reducer shared
// by up to 8 requesters. A granted 16-bit number is folded three times (one
// fold per clock) by weighting even bits 1 and odd bits 2, which keeps the
// residue mod 3; the final value is 0 or 3 exactly when the number divides.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        div3_check_scheduler_if.slave (request / response bundle)
//   busy       high whenever the FSM is not in IDLE
//   cnt_total  responses delivered (stats build only, else 0)
//   cnt_div3   responses delivered with rsp_div3=1 (stats build only, else 0)
//
// Build option: define DIV3_SCHED_STATS_EN to build the two 16-bit wrapping
// response counters; otherwise cnt_total/cnt_div3 are tied to zero.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for any req_valid; grants and captures in same cycle
// REDUCE | three fold passes on acc, verdict registered on the third
// DONE   | response presented, held until rsp_ready
// ---------------------------------------------------------------------------
module div3_check_scheduler #(
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    div3_check_scheduler_if.slave      bus,
    output logic                       busy,
    output logic [15:0]                cnt_total,
    output logic [15:0]                cnt_div3
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   last_grant_q;
    logic [2:0]   id_q;
    logic [15:0]  acc_q;
    logic [15:0]  orig_q;
    logic [1:0]   pass_cnt_q;
    logic         div3_q;

    logic             grant_found;
    logic [2:0]       grant_idx;
    logic [NREQ-1:0]  grant_vec;
    logic [15:0]      grant_num;
    logic [15:0]      acc_next;
    logic             last_pass;
    logic             rsp_fire;

    // Requester index reached by stepping 'step' slots past 'last', wrapping.
    function automatic int rr_slot(input logic [2:0] last, input int step);
        int s;
        s = int'(last) + step;
        if (s >= NREQ) s = s - NREQ;
        return s;
    endfunction

    // One fold: even bits weigh 1, odd bits weigh 2 (2^2k = 1, 2^(2k+1) = 2 mod 3).
    function automatic logic [15:0] fold(input logic [15:0] a);
        logic [4:0] ev;
        logic [4:0] od;
        ev = '0;
        od = '0;
        for (int b = 0; b < 8; b++) begin
            ev = ev + {4'd0, a[2*b]};
            od = od + {4'd0, a[2*b+1]};
        end
        return {11'd0, ev} + {10'd0, od, 1'b0};
    endfunction

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        grant_num   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && bus.req_valid[i] && (rr_slot(last_grant_q, k) == i)) begin
                    grant_found  = 1'b1;
                    grant_idx    = 3'(i);
                    grant_vec[i] = 1'b1;
                    grant_num    = bus.req_number[16*i +: 16];
                end
            end
        end
    end

    assign acc_next  = fold(acc_q);
    assign last_pass = (pass_cnt_q == 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_found)   state_d = S_REDUCE;
            S_REDUCE: if (last_pass)     state_d = S_DONE;
            S_DONE:   if (bus.rsp_ready) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 3'(NREQ - 1);
            id_q         <= '0;
            acc_q        <= '0;
            orig_q       <= '0;
            pass_cnt_q   <= '0;
            div3_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        acc_q        <= grant_num;
                        orig_q       <= grant_num;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        pass_cnt_q   <= '0;
                    end
                end
                S_REDUCE: begin
                    acc_q      <= acc_next;
                    pass_cnt_q <= pass_cnt_q + 2'd1;
                    if (last_pass) begin
                        div3_q <= (acc_next == 16'd0) || (acc_next == 16'd3);
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so the grant clears immediately while reset is asserted.
    assign bus.req_ready  = (state_q == S_IDLE && rst_n) ? grant_vec : '0;
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_number = orig_q;
    assign bus.rsp_div3   = div3_q;
    assign busy           = (state_q != S_IDLE);

    assign rsp_fire = (state_q == S_DONE) && bus.rsp_ready;

`ifdef DIV3_SCHED_STATS_EN
    logic [15:0] cnt_total_q;
    logic [15:0] cnt_div3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_div3_q  <= '0;
        end else if (rsp_fire) begin
            cnt_total_q <= cnt_total_q + 16'd1;
            if (div3_q) cnt_div3_q <= cnt_div3_q + 16'd1;
        end
    end

    assign cnt_total = cnt_total_q;
    assign cnt_div3  = cnt_div3_q;
`else
    logic unused_fire;
    assign unused_fire = rsp_fire;
    assign cnt_total   = 16'd0;
    assign cnt_div3    = 16'd0;
`endif

endmodule

// File: tb/tb_div3_check_scheduler.sv
module tb_div3_check_scheduler;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] cnt_total;
    logic [15:0] cnt_div3;

    div3_check_scheduler_if #(.NREQ(NREQ)) bus ();

    div3_check_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .busy      (busy),
        .cnt_total (cnt_total),
        .cnt_div3  (cnt_div3)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference counters: only move when the stats build is enabled.
    logic [15:0] exp_total = '0;
    logic [15:0] exp_div3  = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == c && v[i]) return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [15:0] rand_num();
        logic [31:0] t;
        t = $urandom;
        if (t[31:29] == 3'd0) begin
            case (t[2:0])
                3'd0: return 16'hFFFF;
                3'd1: return 16'hFFFE;
                3'd2: return 16'd0;
                3'd3: return 16'd1;
                3'd4: return 16'd3;
                default: return 16'h5555;
            endcase
        end
        return t[15:0];
    endfunction

    task automatic note_rsp(input logic [15:0] n);
`ifdef DIV3_SCHED_STATS_EN
        exp_total = exp_total + 16'd1;
        if (n % 3 == 0) exp_div3 = exp_div3 + 16'd1;
`else
        if (n == 16'hxxxx) exp_total = exp_total;
`endif
    endtask

    // Drive point is 1 time unit after the rising edge; sampling 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        exp_total = '0;
        exp_div3  = '0;
    endtask

    // Issue one request on requester r with rsp_ready high; report grant vector,
    // cycles from grant to rsp_valid (-1 if none) and {id, number, div3}.
    task automatic run_one(input int r, input logic [15:0] n,
                           output logic [NREQ-1:0] g, output int lat,
                           output logic [19:0] got);
        bus.req_number[16*r +: 16] = n;
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.rsp_ready = 1'b1;
        g = '0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (bus.req_ready != '0) begin
                g = bus.req_ready;
                next_cycle();
                break;
            end
            next_cycle();
        end
        bus.req_valid = '0;
        lat = -1;
        got = '0;
        for (int c = 1; c <= 12; c++) begin
            #2;
            if (bus.rsp_valid) begin
                lat = c;
                got = {bus.rsp_id, bus.rsp_number, bus.rsp_div3};
                next_cycle();
                break;
            end
            next_cycle();
        end
        if (lat > 0) note_rsp(n);
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] g;
        rst_n = 1'b0;
        bus.req_valid  = '0;
        bus.req_number = '0;
        bus.rsp_ready  = 1'b0;
        #3;
        n_total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_number, bus.rsp_div3,
             busy, cnt_total, cnt_div3} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d num=%h d=%b busy=%b ct=%0d cd=%0d required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_number, bus.rsp_div3,
                     busy, cnt_total, cnt_div3);
        end else n_pass++;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        exp_total = '0;
        exp_div3  = '0;

        // Reach DONE with a held response, then reset mid-cycle.
        bus.req_number[15:0] = 16'h00A5;
        bus.req_valid = 4'b0001;
        #2;
        g = bus.req_ready;
        n_total++;
        if (g !== 4'b0001) $display("FAIL reset_first_grant: got %b required 0001", g);
        else n_pass++;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        n_total++;
        if ({bus.rsp_valid, busy, bus.rsp_number} !== {1'b1, 1'b1, 16'h00A5})
            $display("FAIL reset_predone: got v=%b busy=%b num=%h required 1 1 00a5",
                     bus.rsp_valid, busy, bus.rsp_number);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_number, bus.rsp_div3,
             busy, cnt_total, cnt_div3} !== '0)
            $display("FAIL reset_async_clear: got v=%b num=%h busy=%b required all 0",
                     bus.rsp_valid, bus.rsp_number, busy);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        int lat;
        logic [19:0] got;
        run_one(0, 16'd9, g, lat, got);
        n_total++;
        if (g !== 4'b0001) $display("FAIL single_grant: got %b required 0001", g);
        else n_pass++;
        n_total++;
        if (lat != 4) $display("FAIL single_latency: got %0d required 4", lat);
        else n_pass++;
        n_total++;
        if (got !== {3'd0, 16'd9, 1'b1})
            $display("FAIL single_rsp: got id=%0d num=%0d d=%b required 0 9 1", got[19:17], got[16:1], got[0]);
        else n_pass++;
    endtask

    task automatic test_edges();
        logic [15:0] vals [6];
        logic        exps [6];
        logic [NREQ-1:0] g;
        int lat;
        logic [19:0] got;
        vals = '{16'hFFFF, 16'hFFFE, 16'd0, 16'd1, 16'd3, 16'h5555};
        exps = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_one(2, vals[i], g, lat, got);
            n_total++;
            if (g !== 4'b0100) $display("FAIL edge_grant[%0d]: got %b required 0100", i, g);
            else n_pass++;
            n_total++;
            if (lat != 4) $display("FAIL edge_latency[%0d]: got %0d required 4", i, lat);
            else n_pass++;
            n_total++;
            if (got !== {3'd2, vals[i], exps[i]})
                $display("FAIL edge_rsp[%0d]: got id=%0d num=%h d=%b required 2 %h %b",
                         i, got[19:17], got[16:1], got[0], vals[i], exps[i]);
            else n_pass++;
        end
        n_total++;
        if ({cnt_total, cnt_div3} !== {exp_total, exp_div3})
            $display("FAIL edge_counters: got %0d/%0d required %0d/%0d", cnt_total, cnt_div3, exp_total, exp_div3);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int order [5];
        logic [15:0] nums [4];
        logic [NREQ-1:0] g;
        int wait_c;
        int lat;
        logic [19:0] got;
        order = '{0, 1, 2, 3, 0};
        nums  = '{16'd3, 16'd4, 16'd5, 16'd6};
        pulse_reset();
        for (int r = 0; r < NREQ; r++) bus.req_number[16*r +: 16] = nums[r];
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            g = '0;
            wait_c = -1;
            for (int c = 0; c < 10; c++) begin
                #2;
                if (bus.req_ready != '0) begin
                    g = bus.req_ready;
                    wait_c = c;
                    next_cycle();
                    break;
                end
                next_cycle();
            end
            if (i == 4) bus.req_valid = '0;
            n_total++;
            if (g !== NREQ'(1 << order[i])) $display("FAIL fair_grant[%0d]: got %b required idx %0d", i, g, order[i]);
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (wait_c != 0) $display("FAIL fair_back_to_back[%0d]: grant after %0d idle cycles required 0", i, wait_c);
                else n_pass++;
            end
            lat = -1;
            got = '0;
            for (int c = 1; c <= 12; c++) begin
                #2;
                if (bus.rsp_valid) begin
                    lat = c;
                    got = {bus.rsp_id, bus.rsp_number, bus.rsp_div3};
                    next_cycle();
                    break;
                end
                next_cycle();
            end
            if (lat > 0) note_rsp(nums[order[i]]);
            n_total++;
            if (got !== {3'(order[i]), nums[order[i]], nums[order[i]] % 3 == 0})
                $display("FAIL fair_rsp[%0d]: got id=%0d num=%0d d=%b lat=%0d", i, got[19:17], got[16:1], got[0], lat);
            else n_pass++;
            if (i == 3) begin
                n_total++;
`ifdef DIV3_SCHED_STATS_EN
                if ({cnt_total, cnt_div3} !== {16'd4, 16'd2})
                    $display("FAIL fair_counters: got %0d/%0d required 4/2", cnt_total, cnt_div3);
`else
                if ({cnt_total, cnt_div3} !== {16'd0, 16'd0})
                    $display("FAIL fair_counters: got %0d/%0d required 0/0", cnt_total, cnt_div3);
`endif
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] n;
        logic [15:0] n2;
        logic [NREQ-1:0] g;
        logic [31:0] t;
        logic seen;
        logic [19:0] got;
        t = $urandom;
        n = t[15:0];
        bus.req_number[16 +: 16] = n;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        #2;
        g = bus.req_ready;
        n_total++;
        if (g !== 4'b0010) $display("FAIL bp_grant: got %b required 0010", g);
        else n_pass++;
        next_cycle();
        n2 = rand_num();
        bus.req_number[0 +: 16]  = rand_num();
        bus.req_number[32 +: 16] = n2;
        bus.req_number[48 +: 16] = rand_num();
        bus.req_valid = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        n_total++;
        if (!seen) $display("FAIL bp_rsp_timeout: got no rsp_valid required one");
        else n_pass++;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            #2;
            n_total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_number, bus.rsp_div3, bus.req_ready}
                !== {1'b1, 3'd1, n, n % 3 == 0, 4'b0000})
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d num=%h d=%b rdy=%b required 1 1 %h %b 0000",
                         c, bus.rsp_valid, bus.rsp_id, bus.rsp_number, bus.rsp_div3, bus.req_ready, n, n % 3 == 0);
            else n_pass++;
            next_cycle();
        end
        bus.rsp_ready = 1'b1;
        #2;
        n_total++;
        if (bus.rsp_valid !== 1'b1) $display("FAIL bp_release: got rsp_valid=%b required 1", bus.rsp_valid);
        else n_pass++;
        next_cycle();
        note_rsp(n);
        #2;
        g = bus.req_ready;
        n_total++;
        if (g !== 4'b0100) $display("FAIL bp_next_grant: got %b required 0100", g);
        else n_pass++;
        next_cycle();
        bus.req_valid = '0;
        seen = 1'b0;
        got = '0;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                got = {bus.rsp_id, bus.rsp_number, bus.rsp_div3};
                next_cycle();
                break;
            end
            next_cycle();
        end
        if (seen) note_rsp(n2);
        n_total++;
        if (got !== {3'd2, n2, n2 % 3 == 0})
            $display("FAIL bp_drain: got id=%0d num=%h d=%b required 2 %h %b", got[19:17], got[16:1], got[0], n2, n2 % 3 == 0);
        else n_pass++;
        n_total++;
        if ({cnt_total, cnt_div3} !== {exp_total, exp_div3})
            $display("FAIL bp_counters: got %0d/%0d required %0d/%0d", cnt_total, cnt_div3, exp_total, exp_div3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g;
        logic [15:0] n1;
        logic stale;
        logic seen;
        logic [19:0] got;
        bus.req_number[0 +: 16] = 16'h1234;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #2;
        g = bus.req_ready;
        n_total++;
        if (g !== 4'b0001) $display("FAIL rmid_grant0: got %b required 0001", g);
        else n_pass++;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, bus.rsp_valid} !== 2'b00) $display("FAIL rmid_clear: got busy=%b v=%b required 0 0", busy, bus.rsp_valid);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        exp_total = '0;
        exp_div3  = '0;
        n1 = rand_num();
        bus.req_number[16 +: 16] = n1;
        bus.req_number[48 +: 16] = rand_num();
        bus.req_valid = 4'b1010;
        stale = 1'b0;
        g = '0;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (bus.rsp_valid) stale = 1'b1;
            if (bus.req_ready != '0) begin
                g = bus.req_ready;
                next_cycle();
                break;
            end
            next_cycle();
        end
        bus.req_valid = '0;
        n_total++;
        if (g !== 4'b0010) $display("FAIL rmid_first_grant: got %b required 0010", g);
        else n_pass++;
        seen = 1'b0;
        got = '0;
        for (int c = 1; c <= 12; c++) begin
            #2;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                got = {bus.rsp_id, bus.rsp_number, bus.rsp_div3};
                if (c != 4) stale = 1'b1;
                next_cycle();
                break;
            end
            next_cycle();
        end
        if (seen) note_rsp(n1);
        n_total++;
        if (stale) $display("FAIL rmid_stale: got unexpected rsp_valid timing required none before T+4");
        else n_pass++;
        n_total++;
        if (got !== {3'd1, n1, n1 % 3 == 0})
            $display("FAIL rmid_rsp: got id=%0d num=%h d=%b required 1 %h %b", got[19:17], got[16:1], got[0], n1, n1 % 3 == 0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        logic [15:0]     pnum [NREQ];
        logic            outst;
        int              gcyc;
        int              mlast;
        int              e_id;
        logic [15:0]     e_num;
        logic [NREQ-1:0] exp_g;
        logic            exp_v;
        int              p;
        logic [31:0]     t;
        pulse_reset();
        pend  = '0;
        outst = 1'b0;
        gcyc  = 0;
        mlast = NREQ - 1;
        e_id  = 0;
        e_num = '0;
        for (int r = 0; r < NREQ; r++) pnum[r] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (pend[r]) begin
                    if ($urandom_range(0, 19) == 0) pend[r] = 1'b0;
                end else if (cyc < 560 && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pnum[r] = rand_num();
                end
                if (pend[r]) bus.req_number[16*r +: 16] = pnum[r];
                else begin
                    t = $urandom;
                    bus.req_number[16*r +: 16] = t[15:0];
                end
            end
            bus.req_valid = pend;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #2;
            exp_g = '0;
            p = -1;
            if (!outst && pend != '0) begin
                p = rr_pick(pend, mlast);
                exp_g[p] = 1'b1;
            end
            n_total++;
            if (bus.req_ready !== exp_g) $display("FAIL rand_grant@%0d: got %b required %b", cyc, bus.req_ready, exp_g);
            else n_pass++;
            exp_v = outst && (cyc - gcyc >= 4);
            n_total++;
            if (bus.rsp_valid !== exp_v) $display("FAIL rand_valid@%0d: got %b required %b", cyc, bus.rsp_valid, exp_v);
            else n_pass++;
            if (exp_v && bus.rsp_valid) begin
                n_total++;
                if ({bus.rsp_id, bus.rsp_number, bus.rsp_div3} !== {3'(e_id), e_num, e_num % 3 == 0})
                    $display("FAIL rand_rsp@%0d: got id=%0d num=%h d=%b required %0d %h %b",
                             cyc, bus.rsp_id, bus.rsp_number, bus.rsp_div3, e_id, e_num, e_num % 3 == 0);
                else n_pass++;
            end
            n_total++;
            if ({cnt_total, cnt_div3} !== {exp_total, exp_div3})
                $display("FAIL rand_counters@%0d: got %0d/%0d required %0d/%0d", cyc, cnt_total, cnt_div3, exp_total, exp_div3);
            else n_pass++;
            if (exp_v && bus.rsp_ready) begin
                outst = 1'b0;
                note_rsp(e_num);
            end
            if (p >= 0) begin
                outst   = 1'b1;
                gcyc    = cyc;
                e_id    = p;
                e_num   = pnum[p];
                mlast   = p;
                pend[p] = 1'b0;
            end
            next_cycle();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!busy) break;
            next_cycle();
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL rand_drain: got busy=%b required 0", busy);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_number = '0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_single();
        test_edges();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
